// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
// The entry layout is fixed here so fetch, queue and decode agree on it.
package fetch_queue_pkg;

  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(
    input logic [XLEN-1:0] instr,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] pc_plus4
  );
    fetch_entry_t e;
    e.instr    = instr;
    e.pc       = pc;
    e.pc_plus4 = pc_plus4;
    return e;
  endfunction

  // A bubble carries the NOP encoding with zeroed PC fields.
  function automatic fetch_entry_t bubble_entry();
    return make_entry(NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}});
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master = fetch+decode side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  logic                   PushF;
  logic [XLEN-1:0]        InstrF;
  logic [XLEN-1:0]        PCF;
  logic [XLEN-1:0]        PCPlus4F;
  logic                   ReadyF;
  logic                   PopD;
  logic                   ValidD;
  logic [XLEN-1:0]        InstrD;
  logic [XLEN-1:0]        PCD;
  logic [XLEN-1:0]        PCPlus4D;
  logic                   Flush;
  logic [$clog2(DEPTH):0] Count;

  modport master (
    output PushF, InstrF, PCF, PCPlus4F, PopD, Flush,
    input  ReadyF, ValidD, InstrD, PCD, PCPlus4D, Count
  );

  modport slave (
    input  PushF, InstrF, PCF, PCPlus4F, PopD, Flush,
    output ReadyF, ValidD, InstrD, PCD, PCPlus4D, Count
  );

endinterface

// File: rtl/fetch_queue_chk.sv
// Occupancy sanity checker for fetch_queue; kept outside the datapath.
module fetch_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic [$clog2(DEPTH):0] count_i,
  input logic                   valid_i,
  input logic                   ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
    count_i <= CW'(DEPTH));

  a_valid_tracks_count: assert property (@(posedge clk_i) disable iff (!rst_i)
    valid_i == (count_i != CW'(0)));

  a_ready_tracks_count: assert property (@(posedge clk_i) disable iff (!rst_i)
    ready_i == (count_i != CW'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: FWFT head, NOP bubble when
// empty, single-cycle flush on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          XLEN  = fetch_queue_pkg::XLEN,
  parameter int          DEPTH = fetch_queue_pkg::DEPTH,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;
  fetch_entry_t  head_s;

  // Full/empty come from the occupancy count only, so they are registered.
  assign empty_s    = (count_q == CW'(0));
  assign bus.ReadyF = (count_q != CNT_MAX);
  assign bus.ValidD = !empty_s;
  assign bus.Count  = count_q;

  assign push_s = bus.PushF && bus.ReadyF && !bus.Flush;
  assign pop_s  = bus.PopD  && bus.ValidD && !bus.Flush;

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.Flush) begin
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; intentionally not reset, the count masks stale slots.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q] <= make_entry(bus.InstrF, bus.PCF, bus.PCPlus4F);
    end
  end

  // Head mux with bubble forcing so decode never sees stale storage.
  always_comb begin
    head_s = mem[rd_ptr_q];
    if (empty_s) begin
      head_s.instr    = NOP;
      head_s.pc       = {XLEN{1'b0}};
      head_s.pc_plus4 = {XLEN{1'b0}};
    end else begin
      head_s = mem[rd_ptr_q];
    end
  end

  assign bus.InstrD   = head_s.instr;
  assign bus.PCD      = head_s.pc;
  assign bus.PCPlus4D = head_s.pc_plus4;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): reset, fill, concurrency, flush,
// underflow and pointer wrap, each with hand-computed expectations.
module tb_fetch_queue;

  localparam logic [31:0] NOP_E = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks_n = 0;
  int   fails_n  = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .NOP(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_queue_chk #(.DEPTH(4)) chk (
    .clk_i   (clk),
    .rst_i   (rst),
    .count_i (bus.Count),
    .valid_i (bus.ValidD),
    .ready_i (bus.ReadyF)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic cyc(input logic push, input logic [31:0] pc,
                     input logic pop, input logic flush);
    bus.PushF    = push;
    bus.PCF      = pc;
    bus.InstrF   = instr_of(pc);
    bus.PCPlus4F = pc + 32'd4;
    bus.PopD     = pop;
    bus.Flush    = flush;
    @(posedge clk);
    #1;
    bus.PushF = 1'b0;
    bus.PopD  = 1'b0;
    bus.Flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.PushF = 1'b0; bus.PopD = 1'b0; bus.Flush = 1'b0;
    bus.PCF = 32'd0; bus.InstrF = 32'd0; bus.PCPlus4F = 32'd0;
    #2;
    checks_n++;
    if (bus.Count !== 3'd0 || bus.ValidD !== 1'b0 || bus.ReadyF !== 1'b1) begin
      fails_n++;
      $display("FAIL reset_state count=%0d valid=%b ready=%b exp 0/0/1",
               bus.Count, bus.ValidD, bus.ReadyF);
    end
    checks_n++;
    if (bus.InstrD !== NOP_E || bus.PCD !== 32'd0 || bus.PCPlus4D !== 32'd0) begin
      fails_n++;
      $display("FAIL reset_head instr=%h pc=%h pc4=%h exp %h/0/0",
               bus.InstrD, bus.PCD, bus.PCPlus4D, NOP_E);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'(4 * i), 1'b0, 1'b0);
      checks_n++;
      if (bus.Count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
        fails_n++;
        $display("FAIL fill_count[%0d] got=%0d", i, bus.Count);
      end
    end
    checks_n++;
    if (bus.ReadyF !== 1'b0 || bus.ValidD !== 1'b1) begin
      fails_n++;
      $display("FAIL fill_full ready=%b valid=%b exp 0/1", bus.ReadyF, bus.ValidD);
    end
    for (int i = 0; i < 4; i++) begin
      checks_n++;
      if (bus.PCD !== 32'(4 * i) || bus.InstrD !== instr_of(32'(4 * i))
          || bus.PCPlus4D !== 32'(4 * i + 4)) begin
        fails_n++;
        $display("FAIL fill_pop_order[%0d] pc=%h instr=%h exp pc=%h",
                 i, bus.PCD, bus.InstrD, 32'(4 * i));
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
    end
    checks_n++;
    if (bus.Count !== 3'd0 || bus.InstrD !== NOP_E) begin
      fails_n++;
      $display("FAIL fill_drained count=%0d instr=%h exp 0/%h", bus.Count, bus.InstrD, NOP_E);
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h50 + 32'(4 * i), 1'b0, 1'b0);
    cyc(1'b1, 32'h20, 1'b1, 1'b0);
    checks_n++;
    if (bus.Count !== 3'd3 || bus.PCD !== 32'h54) begin
      fails_n++;
      $display("FAIL conc_full count=%0d pc=%h exp 3/54", bus.Count, bus.PCD);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h60, 1'b1, 1'b0);
    checks_n++;
    if (bus.Count !== 3'd2 || bus.PCD !== 32'h5C) begin
      fails_n++;
      $display("FAIL conc_mid count=%0d pc=%h exp 2/5c", bus.Count, bus.PCD);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    checks_n++;
    if (bus.Count !== 3'd1 || bus.PCD !== 32'h60 || bus.InstrD !== instr_of(32'h60)) begin
      fails_n++;
      $display("FAIL conc_tail count=%0d pc=%h exp 1/60", bus.Count, bus.PCD);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h70 + 32'(4 * i), 1'b0, 1'b0);
    checks_n++;
    if (bus.Count !== 3'd3) begin
      fails_n++;
      $display("FAIL flush_pre count=%0d exp 3", bus.Count);
    end
    cyc(1'b1, 32'h7C, 1'b1, 1'b1);
    checks_n++;
    if (bus.Count !== 3'd0 || bus.ValidD !== 1'b0 || bus.InstrD !== NOP_E
        || bus.PCD !== 32'd0 || bus.ReadyF !== 1'b1) begin
      fails_n++;
      $display("FAIL flush_clear count=%0d valid=%b instr=%h pc=%h ready=%b",
               bus.Count, bus.ValidD, bus.InstrD, bus.PCD, bus.ReadyF);
    end
    cyc(1'b1, 32'h40, 1'b0, 1'b0);
    checks_n++;
    if (bus.Count !== 3'd1 || bus.PCD !== 32'h40 || bus.PCPlus4D !== 32'h44
        || bus.InstrD !== instr_of(32'h40)) begin
      fails_n++;
      $display("FAIL flush_refill count=%0d pc=%h pc4=%h exp 1/40/44",
               bus.Count, bus.PCD, bus.PCPlus4D);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      checks_n++;
      if (bus.Count !== 3'd0 || bus.PCD !== 32'd0 || bus.InstrD !== NOP_E) begin
        fails_n++;
        $display("FAIL underflow[%0d] count=%0d pc=%h instr=%h", i, bus.Count, bus.PCD, bus.InstrD);
      end
    end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      checks_n++;
      if (bus.PCD !== 32'h100 + 32'(4 * (k - 1)) || bus.Count !== 3'd1) begin
        fails_n++;
        $display("FAIL wrap[%0d] pc=%h count=%0d exp pc=%h count=1",
                 k, bus.PCD, bus.Count, 32'h100 + 32'(4 * (k - 1)));
      end
      cyc(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0);
    end
    checks_n++;
    if (bus.PCD !== 32'h124 || bus.Count !== 3'd1 || bus.InstrD !== instr_of(32'h124)) begin
      fails_n++;
      $display("FAIL wrap_last pc=%h count=%0d exp 124/1", bus.PCD, bus.Count);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checks_n++;
    if (bus.Count !== 3'd0 || bus.ValidD !== 1'b0 || bus.InstrD !== NOP_E
        || bus.ReadyF !== 1'b1 || bus.PCD !== 32'd0) begin
      fails_n++;
      $display("FAIL reset_midrun count=%0d valid=%b instr=%h ready=%b pc=%h",
               bus.Count, bus.ValidD, bus.InstrD, bus.ReadyF, bus.PCD);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 32'h300, 1'b0, 1'b0);
    checks_n++;
    if (bus.Count !== 3'd1 || bus.PCD !== 32'h300) begin
      fails_n++;
      $display("FAIL reset_recover count=%0d pc=%h exp 1/300", bus.Count, bus.PCD);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_concurrent();
    test_flush();
    test_underflow();
    test_wrap();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
